// File: rtl/trng_pkg.sv
// Shared TRNG definitions: word width, collector defaults, FSM encoding.
// No ports; imported by the collector and its health test.
package trng_pkg;
  localparam int WORD_WIDTH    = 32;
  localparam int DEF_NUM_WORDS = 16;
  localparam int DEF_REP_LIMIT = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_ACK     = 3'd2;
  localparam logic [2:0] ST_DELIVER = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    COLLECT = ST_COLLECT,
    ACK     = ST_ACK,
    DELIVER = ST_DELIVER,
    ERROR   = ST_ERROR
  } state_t;
endpackage

// File: rtl/entropy_rep_test.sv
// Repetition-count health test over accepted entropy words.
// Ports: clk, reset, clear, word_valid, word in; rep_ctr, error (sticky) out.
module entropy_rep_test
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [7:0]            rep_ctr,
  output logic                  error
);

  logic [WORD_WIDTH-1:0] prev;
  logic [7:0]            ctr_next;

  // rep_ctr==0 marks "no previous word yet", so the first word counts 1.
  always_comb begin
    ctr_next = 8'd1;
    if (rep_ctr != 8'd0 && word == prev) begin
      ctr_next = (rep_ctr == 8'hFF) ? rep_ctr : rep_ctr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev    <= '0;
      rep_ctr <= 8'd0;
      error   <= 1'b0;
    end else if (word_valid) begin
      prev    <= word;
      rep_ctr <= ctr_next;
      if (ctr_next >= 8'(REP_LIMIT)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// Entropy word collector: syn/ack capture, health test, block packing.
// Ports: entropy_* source handshake, block_* mixer handshake, status counters.
module entropy_collector
  import trng_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            entropy_enabled,
  input  logic                            entropy_syn,
  input  logic [WORD_WIDTH-1:0]           entropy_data,
  output logic                            entropy_ack,
  output logic                            block_syn,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] block_data,
  input  logic                            block_ack,
  output logic [6:0]                      word_count,
  output logic [31:0]                     words_total,
  output logic                            health_error
);

  state_t     state;
  logic       offered;
  logic       capture;
  logic       rep_clear;
  logic [7:0] rep_ctr;

  assign offered   = entropy_syn && entropy_enabled;
  assign capture   = enable && (state == COLLECT) && offered;
  assign rep_clear = !enable || (state == IDLE);

  entropy_rep_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rep (
    .clk       (clk),
    .reset     (reset),
    .clear     (rep_clear),
    .word_valid(capture),
    .word      (entropy_data),
    .rep_ctr   (rep_ctr),
    .error     (health_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      entropy_ack <= 1'b0;
      block_syn   <= 1'b0;
      block_data  <= '0;
      word_count  <= 7'd0;
      words_total <= 32'd0;
    end else if (!enable) begin
      // Flush: drop any partial/undelivered block, keep the total.
      state       <= IDLE;
      entropy_ack <= 1'b0;
      block_syn   <= 1'b0;
      word_count  <= 7'd0;
    end else begin
      entropy_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          word_count <= 7'd0;
          state      <= COLLECT;
        end
        COLLECT: begin
          if (offered) begin
            entropy_ack <= 1'b1;
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (word_count == 7'(i)) begin
                block_data[WORD_WIDTH*i +: WORD_WIDTH] <= entropy_data;
              end
            end
            word_count  <= word_count + 7'd1;
            words_total <= words_total + 32'd1;
            state       <= ACK;
          end
        end
        ACK: begin
          // Syn is ignored here so the source can retire the acked word.
          if (rep_ctr >= 8'(REP_LIMIT)) begin
            state <= ERROR;
          end else if (word_count == 7'(NUM_WORDS)) begin
            block_syn <= 1'b1;
            state     <= DELIVER;
          end else begin
            state <= COLLECT;
          end
        end
        DELIVER: begin
          if (block_ack) begin
            block_syn  <= 1'b0;
            word_count <= 7'd0;
            state      <= COLLECT;
          end
        end
        ERROR: begin
          block_syn <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Scoreboard bench for entropy_collector: stimulus queues expected acks
// and blocks, a negedge monitor pops and compares as the DUT responds.
module tb_entropy_collector;
  localparam int NW = 16;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          entropy_enabled = 1'b0;
  logic          entropy_syn = 1'b0;
  logic [WW-1:0] entropy_data = '0;
  logic          entropy_ack;
  logic          block_syn;
  logic [NW*WW-1:0] block_data;
  logic          block_ack = 1'b0;
  logic [6:0]    word_count;
  logic [31:0]   words_total;
  logic          health_error;

  entropy_collector #(.NUM_WORDS(NW), .REP_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .entropy_enabled(entropy_enabled),
    .entropy_syn    (entropy_syn),
    .entropy_data   (entropy_data),
    .entropy_ack    (entropy_ack),
    .block_syn      (block_syn),
    .block_data     (block_data),
    .block_ack      (block_ack),
    .word_count     (word_count),
    .words_total    (words_total),
    .health_error   (health_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   total;
    int   wc;
    logic herr;
    int   gap;
  } ack_exp_t;

  ack_exp_t         ack_q[$];
  logic [NW*WW-1:0] blk_q[$];
  int               blk_tot_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ack = 0;
  int exp_total = 0;
  logic bsyn_d = 1'b0;
  logic inc_mode = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NW*WW-1:0] mk_blk(input logic [WW-1:0] base);
    logic [NW*WW-1:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[WW*i +: WW] = base + WW'(i);
    return v;
  endfunction

  // Monitor: pops expectations whenever the DUT acks or presents a block.
  always @(negedge clk) begin
    ack_exp_t         e;
    logic [NW*WW-1:0] b;
    int               t;
    if (entropy_ack) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 64'(words_total), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = ack_q.pop_front();
        chk("ack_total", 64'(words_total), 64'(e.total));
        chk("ack_wc", 64'(word_count), 64'(e.wc));
        chk("ack_herr", 64'(health_error), 64'(e.herr));
        if (e.gap > 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
      end
      last_ack = cyc;
    end
    if (block_syn && !bsyn_d) begin
      if (blk_q.size() == 0) begin
        chk("unexpected_block", 64'(words_total), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        b = blk_q.pop_front();
        t = blk_tot_q.pop_front();
        chk("blk_total", 64'(words_total), 64'(t));
        chk("blk_wc", 64'(word_count), 64'(NW));
        n_cmp++;
        if (block_data !== b) begin
          n_bad++;
          $display("FAIL blk_data: got %h expected %h", block_data, b);
        end
      end
    end
    bsyn_d = block_syn;
  end

  task automatic tick();
    @(negedge clk);
    if (entropy_ack && inc_mode) entropy_data = entropy_data + 1;
  endtask

  task automatic push_acks(input int n, input int wc0, input bit trip,
                           input bit gap2);
    ack_exp_t e;
    for (int i = 1; i <= n; i++) begin
      exp_total++;
      e.total = exp_total;
      e.wc    = wc0 + i;
      e.herr  = trip && (i == n);
      e.gap   = (gap2 && i > 1) ? 2 : 0;
      ack_q.push_back(e);
    end
  endtask

  task automatic push_blk(input logic [WW-1:0] base);
    blk_q.push_back(mk_blk(base));
    blk_tot_q.push_back(exp_total);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int k = 0;
    int t = 0;
    while (k < n && t < budget) begin
      tick();
      t++;
      if (entropy_ack) k++;
    end
    if (k < n) chk("ack_timeout", 64'(k), 64'(n));
  endtask

  task automatic wait_blk(input int budget);
    int t = 0;
    while (!block_syn && t < budget) begin
      tick();
      t++;
    end
    chk("blk_timeout", 64'(block_syn), 64'd1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ack"}, 64'(entropy_ack), 64'd0);
    chk({nm, "_bsyn"}, 64'(block_syn), 64'd0);
    chk({nm, "_bdata"}, 64'(|block_data), 64'd0);
    chk({nm, "_wc"}, 64'(word_count), 64'd0);
    chk({nm, "_total"}, 64'(words_total), 64'd0);
    chk({nm, "_herr"}, 64'(health_error), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk_reset("rst_init");

    // Incrementing words 0x1..0x10 fill one block.
    inc_mode = 1'b1;
    entropy_data = 32'h1;
    entropy_enabled = 1'b1;
    entropy_syn = 1'b1;
    push_acks(16, 0, 0, 1);
    push_blk(32'h1);
    enable = 1'b1;
    wait_blk(60);
    chk("t1_total", 64'(words_total), 64'd16);
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    chk("t1_release_bsyn", 64'(block_syn), 64'd0);
    chk("t1_release_wc", 64'(word_count), 64'd0);
    push_acks(1, 0, 0, 0);
    tick();
    chk("t1_ack_resume", 64'(entropy_ack), 64'd1);
    enable = 1'b0;
    tick();
    chk("t1_flush_wc", 64'(word_count), 64'd0);
    chk("t1_flush_total", 64'(words_total), 64'd17);

    // Constant data trips the repetition test on the 4th word.
    inc_mode = 1'b0;
    entropy_data = 32'h0102_0304;
    push_acks(4, 0, 1, 1);
    enable = 1'b1;
    wait_acks(4, 40);
    repeat (30) tick();
    chk("t2_herr", 64'(health_error), 64'd1);
    chk("t2_bsyn", 64'(block_syn), 64'd0);
    chk("t2_wc", 64'(word_count), 64'd4);
    enable = 1'b0;
    tick();
    chk("t2_clear_herr", 64'(health_error), 64'd0);
    chk("t2_clear_wc", 64'(word_count), 64'd0);

    // Restart, then hold the full block without block_ack.
    inc_mode = 1'b1;
    entropy_data = 32'h100;
    push_acks(16, 0, 0, 1);
    push_blk(32'h100);
    enable = 1'b1;
    wait_blk(60);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold_data", 64'(block_data == mk_blk(32'h100)), 64'd1);
      chk("t3_hold_bsyn", 64'(block_syn), 64'd1);
    end
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    entropy_syn = 1'b0;
    chk("t3_release", 64'(block_syn), 64'd0);

    // Source not enabled: syn alone never offers a word.
    entropy_enabled = 1'b0;
    entropy_syn = 1'b1;
    repeat (10) tick();
    chk("t4_total", 64'(words_total), 64'd37);
    chk("t4_wc", 64'(word_count), 64'd0);
    entropy_enabled = 1'b1;
    entropy_syn = 1'b0;
    inc_mode = 1'b0;
    for (int j = 0; j < 3; j++) begin
      entropy_data = 32'hA0 + 32'(16 * j);
      push_acks(1, j, 0, 0);
      entropy_syn = 1'b1;
      tick();
      chk("t4_pulse_ack", 64'(entropy_ack), 64'd1);
      entropy_syn = 1'b0;
      repeat (3) tick();
    end
    chk("t4_gap_total", 64'(words_total), 64'd40);

    // Enable dropped after 5 words, then a fresh full block.
    enable = 1'b0;
    tick();
    chk("t5_pre_wc", 64'(word_count), 64'd0);
    inc_mode = 1'b1;
    entropy_data = 32'h200;
    push_acks(5, 0, 0, 1);
    entropy_syn = 1'b1;
    enable = 1'b1;
    wait_acks(5, 30);
    enable = 1'b0;
    tick();
    chk("t5_flush_wc", 64'(word_count), 64'd0);
    chk("t5_flush_ack", 64'(entropy_ack), 64'd0);
    chk("t5_flush_total", 64'(words_total), 64'd45);
    entropy_data = 32'h300;
    push_acks(16, 0, 0, 1);
    push_blk(32'h300);
    enable = 1'b1;
    wait_blk(60);

    // Reset in DELIVER, then in ACK after 3 repeats.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("rst_deliver");
    exp_total = 0;
    inc_mode = 1'b0;
    entropy_data = 32'h55;
    push_acks(3, 0, 0, 1);
    wait_acks(3, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("rst_ack");
    exp_total = 0;
    push_acks(3, 0, 0, 1);
    wait_acks(3, 20);
    entropy_syn = 1'b0;
    repeat (5) tick();
    chk("t6_herr", 64'(health_error), 64'd0);
    chk("t6_wc", 64'(word_count), 64'd3);
    chk("t6_total", 64'(words_total), 64'd3);

    chk("ack_q_left", 64'(ack_q.size()), 64'd0);
    chk("blk_q_left", 64'(blk_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
